// File: rtl/ldtu_pkg.sv
`default_nettype none
// ============================================================================
//  Package : ldtu_pkg
//  Purpose : Shared definitions for the LiTe-DTU output FIFO read path:
//            word_type codes, default idle/trailer constants, scheduler
//            state encoding and the saturating error-counter helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package ldtu_pkg;

  // word_type codes carried alongside every output word
  localparam logic [1:0] WT_IDLE  = 2'b00;
  localparam logic [1:0] WT_DATA  = 2'b01;
  localparam logic [1:0] WT_TRAIL = 2'b10;

  // defaults for the idle filler word and the trailer tag byte
  localparam logic [31:0] IDLE_PATTERN_DEF = 32'hEAAA_AAAA;
  localparam logic [7:0]  TRAILER_TAG_DEF  = 8'hD2;

  // scheduler state encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_TRAIL = 1'b1;

  // 6-bit counter that sticks at 63 instead of wrapping
  function automatic logic [5:0] sat_inc6(input logic [5:0] cnt, input logic inc);
    logic [5:0] res;
    res = cnt;
    if (inc && (cnt != 6'h3F)) begin
      res = cnt + 6'd1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldtu_ofifo_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module  : ldtu_ofifo_rd_sched
//  Purpose : Read scheduler and frame builder for the Hamming output FIFO.
//            Issues bounded read pulses, forwards decoded words as a
//            continuous stream (idle-filled) and closes each frame of
//            FrameLen data words with a trailer {tag, frame#, serr, derr}.
//  Ports   : CLK, reset (sync, active-low)
//            empty_signal / full_signal  - FIFO status
//            dec_valid / dec_data / dec_single_err / dec_double_err
//                                        - decoder return path
//            read_signal                 - one-cycle FIFO read request
//            data_out / word_type        - registered output stream
//            overflow_flag / proto_err   - sticky status flags
//  Rev     : 1.0  initial release
// ============================================================================
module ldtu_ofifo_rd_sched
  import ldtu_pkg::*;
#(
  parameter int          Nbits_out   = 32,
  parameter int          FrameLen    = 50,
  parameter int          MaxInFlight = 2,
  parameter logic [31:0] IdlePattern = IDLE_PATTERN_DEF,
  parameter logic [7:0]  TrailerTag  = TRAILER_TAG_DEF
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 empty_signal,
  input  logic                 full_signal,
  input  logic                 dec_valid,
  input  logic [Nbits_out-1:0] dec_data,
  input  logic                 dec_single_err,
  input  logic                 dec_double_err,
  output logic                 read_signal,
  output logic [Nbits_out-1:0] data_out,
  output logic [1:0]           word_type,
  output logic                 overflow_flag,
  output logic                 proto_err
);

  localparam logic [11:0] c_frame_len    = 12'(FrameLen);
  localparam logic [11:0] c_frame_last   = 12'(FrameLen - 1);
  localparam logic [1:0]  c_max_inflight = 2'(MaxInFlight);

  logic [0:0]           state_q, state_d;
  logic                 read_signal_q, read_signal_d;
  logic [Nbits_out-1:0] data_out_q, data_out_d;
  logic [1:0]           word_type_q, word_type_d;
  logic [1:0]           inflight_q, inflight_d;
  logic [11:0]          issued_q, issued_d;
  logic [11:0]          returned_q, returned_d;
  logic [11:0]          frame_num_q, frame_num_d;
  logic [5:0]           serr_cnt_q, serr_cnt_d;
  logic [5:0]           derr_cnt_q, derr_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 proto_q, proto_d;

  logic                 w_issue;
  logic                 w_retire;
  logic                 w_last_word;
  logic [31:0]          w_trailer;

  // inflight and issued advance on the edge that registers read_signal, so
  // a pulse about to appear is already counted and back-to-back decisions
  // cannot overshoot MaxInFlight or FrameLen.
  assign w_issue     = (state_q == ST_RUN) && !empty_signal &&
                       (inflight_q < c_max_inflight) && (issued_q < c_frame_len);
  // never let an unexpected return drive the in-flight count below zero
  assign w_retire    = dec_valid && (inflight_q != 2'd0);
  assign w_last_word = (state_q == ST_RUN) && dec_valid && (returned_q == c_frame_last);
  assign w_trailer   = {TrailerTag, frame_num_q, serr_cnt_q, derr_cnt_q};

  // ---------------------------------------------------------------- registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      read_signal_q <= 1'b0;
      data_out_q    <= Nbits_out'(IdlePattern);
      word_type_q   <= WT_IDLE;
      inflight_q    <= 2'd0;
      issued_q      <= 12'd0;
      returned_q    <= 12'd0;
      frame_num_q   <= 12'd0;
      serr_cnt_q    <= 6'd0;
      derr_cnt_q    <= 6'd0;
      overflow_q    <= 1'b0;
      proto_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_signal_q <= read_signal_d;
      data_out_q    <= data_out_d;
      word_type_q   <= word_type_d;
      inflight_q    <= inflight_d;
      issued_q      <= issued_d;
      returned_q    <= returned_d;
      frame_num_q   <= frame_num_d;
      serr_cnt_q    <= serr_cnt_d;
      derr_cnt_q    <= derr_cnt_d;
      overflow_q    <= overflow_d;
      proto_q       <= proto_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (w_last_word) state_d = ST_TRAIL;
      ST_TRAIL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // ----------------------------------------------------------- outputs/datapath
  always_comb begin
    read_signal_d = w_issue;
    data_out_d    = Nbits_out'(IdlePattern);
    word_type_d   = WT_IDLE;
    issued_d      = issued_q + {11'd0, w_issue};
    returned_d    = returned_q;
    frame_num_d   = frame_num_q;
    serr_cnt_d    = serr_cnt_q;
    derr_cnt_d    = derr_cnt_q;
    inflight_d    = inflight_q;
    overflow_d    = overflow_q | full_signal;
    // a word returning in TRAIL or with nothing outstanding breaks pairing
    proto_d       = proto_q | (dec_valid && ((inflight_q == 2'd0) || (state_q == ST_TRAIL)));

    case ({w_issue, w_retire})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_RUN: begin
        if (dec_valid) begin
          data_out_d  = dec_data;
          word_type_d = WT_DATA;
          returned_d  = returned_q + 12'd1;
          serr_cnt_d  = sat_inc6(serr_cnt_q, dec_single_err);
          derr_cnt_d  = sat_inc6(derr_cnt_q, dec_double_err);
        end
      end
      ST_TRAIL: begin
        // trailer reports the finished frame, then the frame state rolls over
        data_out_d  = Nbits_out'(w_trailer);
        word_type_d = WT_TRAIL;
        issued_d    = 12'd0;
        returned_d  = 12'd0;
        serr_cnt_d  = 6'd0;
        derr_cnt_d  = 6'd0;
        frame_num_d = frame_num_q + 12'd1;
      end
      default: begin
        data_out_d = Nbits_out'(IdlePattern);
      end
    endcase
  end

  assign read_signal   = read_signal_q;
  assign data_out      = data_out_q;
  assign word_type     = word_type_q;
  assign overflow_flag = overflow_q;
  assign proto_err     = proto_q;

endmodule
`default_nettype wire
